// File: rtl/ula_sequencial.sv
// Multi-cycle ALU: single-cycle ADD/logic/compare/shift/move operations,
// iterative shift-add multiply and restoring divide.
// Results and flags are registered and held until the next operation finishes.
//
//   state  | meaning
//   OCIOSO | idle, waiting for inicio
//   ITERA  | multiply/divide engine running, one step per cycle
//   FIM    | results valid, pronto pulses, a new inicio may be accepted
module ula_sequencial #(
  parameter int LARGURA     = 32,
  parameter int LOG_LARGURA = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inicio,
  input  logic [5:0]           seletor,
  input  logic [LARGURA-1:0]   e0,
  input  logic [LARGURA-1:0]   e1,
  output logic [LARGURA-1:0]   s0,
  output logic [LARGURA-1:0]   s1,
  output logic                 c0,
  output logic                 z0,
  output logic                 erro,
  output logic                 ocupado,
  output logic                 pronto
);

  localparam logic [4:0] OP_SOMA  = 5'b00000;
  localparam logic [4:0] OP_SUBT  = 5'b00001;
  localparam logic [4:0] OP_MULT  = 5'b00010;
  localparam logic [4:0] OP_DIVI  = 5'b00011;
  localparam logic [4:0] OP_OU    = 5'b00100;
  localparam logic [4:0] OP_NOU   = 5'b00101;
  localparam logic [4:0] OP_E     = 5'b00110;
  localparam logic [4:0] OP_NE    = 5'b00111;
  localparam logic [4:0] OP_OUEX  = 5'b01000;
  localparam logic [4:0] OP_NOUX  = 5'b01001;
  localparam logic [4:0] OP_MENOR = 5'b01010;
  localparam logic [4:0] OP_MAIOR = 5'b01011;
  localparam logic [4:0] OP_IGUAL = 5'b01100;
  localparam logic [4:0] OP_SHLE  = 5'b01101;
  localparam logic [4:0] OP_SHRI  = 5'b01110;
  localparam logic [4:0] OP_DIFER = 5'b01111;
  localparam logic [4:0] OP_MOVER = 5'b10000;
  localparam logic [4:0] OP_NEGAR = 5'b10001;

  localparam logic [LOG_LARGURA-1:0] CNT_CARGA = LOG_LARGURA'(LARGURA - 1);

  typedef enum logic [1:0] {OCIOSO, ITERA, FIM} estado_t;

  estado_t estado, proximo;

  logic [4:0]             op;
  logic                   sinal;
  logic                   eh_mult, eh_divi, div_zero, multiciclo, aceita;
  logic [LARGURA-1:0]     mag_a, mag_b;

  // engine state
  logic [LARGURA-1:0]     acc_hi, acc_lo, opnd;
  logic [LOG_LARGURA-1:0] cnt;
  logic                   modo_mult, neg_q, neg_r;

  // single-cycle result
  logic [LARGURA-1:0]     res_simples;
  logic                   c_simples;
  logic                   grande;
  logic [LOG_LARGURA-1:0] qtd;

  // engine step and final sign correction
  logic [LARGURA:0]       soma_parc, desloc, tentativa;
  logic [LARGURA-1:0]     passo_hi, passo_lo;
  logic [2*LARGURA-1:0]   produto;
  logic [LARGURA-1:0]     quoc_f, resto_f;

  assign op         = seletor[4:0];
  assign sinal      = seletor[5];
  assign eh_mult    = (op == OP_MULT);
  assign eh_divi    = (op == OP_DIVI);
  assign div_zero   = eh_divi && (e1 == '0);
  assign multiciclo = eh_mult || (eh_divi && !div_zero);
  assign aceita     = inicio && ((estado == OCIOSO) || (estado == FIM));

  // Operand magnitudes; the engine itself is always unsigned
  always_comb begin
    mag_a = (sinal && e0[LARGURA-1]) ? -e0 : e0;
    mag_b = (sinal && e1[LARGURA-1]) ? -e1 : e1;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) estado <= OCIOSO;
    else       estado <= proximo;
  end

  // Next-state and handshake outputs
  always_comb begin
    proximo = estado;
    ocupado = 1'b0;
    pronto  = 1'b0;
    case (estado)
      OCIOSO: begin
        if (inicio) proximo = multiciclo ? ITERA : FIM;
      end
      ITERA: begin
        ocupado = 1'b1;
        if (cnt == '0) proximo = FIM;
      end
      FIM: begin
        pronto = 1'b1;
        if (inicio) proximo = multiciclo ? ITERA : FIM;
        else        proximo = OCIOSO;
      end
      default: proximo = OCIOSO;
    endcase
  end

  // Single-cycle operations, computed straight from the operands at start
  always_comb begin
    res_simples = '0;
    c_simples   = 1'b0;
    grande      = |e1[LARGURA-1:LOG_LARGURA];
    qtd         = e1[LOG_LARGURA-1:0];
    case (op)
      OP_SOMA:  res_simples = e0 + e1;
      OP_SUBT:  res_simples = e0 - e1;
      OP_OU:    res_simples = e0 | e1;
      OP_NOU:   res_simples = ~(e0 | e1);
      OP_E:     res_simples = e0 & e1;
      OP_NE:    res_simples = ~(e0 & e1);
      OP_OUEX:  res_simples = e0 ^ e1;
      OP_NOUX:  res_simples = ~(e0 ^ e1);
      OP_MENOR: c_simples   = sinal ? ($signed(e0) < $signed(e1)) : (e0 < e1);
      OP_MAIOR: c_simples   = sinal ? ($signed(e0) > $signed(e1)) : (e0 > e1);
      OP_IGUAL: c_simples   = (e0 == e1);
      OP_DIFER: c_simples   = (e0 != e1);
      OP_SHLE:  res_simples = grande ? '0 : (e0 << qtd);
      OP_SHRI: begin
        if (grande)     res_simples = sinal ? {LARGURA{e0[LARGURA-1]}} : '0;
        else if (sinal) res_simples = LARGURA'($signed(e0) >>> qtd);
        else            res_simples = e0 >> qtd;
      end
      OP_MOVER: res_simples = e0;
      OP_NEGAR: res_simples = ~e0;
      OP_MULT, OP_DIVI: res_simples = '0;
      default:  res_simples = e1;
    endcase
    if (op == OP_MENOR || op == OP_MAIOR || op == OP_IGUAL || op == OP_DIFER)
      res_simples = {{(LARGURA-1){1'b0}}, c_simples};
  end

  // One engine step: shift-add for multiply, restoring step for divide.
  // Multiply keeps {acc_hi, acc_lo} as partial product / remaining multiplier;
  // divide keeps acc_hi as remainder and acc_lo as dividend-in / quotient-out.
  always_comb begin
    soma_parc = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    desloc    = {acc_hi, acc_lo[LARGURA-1]};
    tentativa = desloc - {1'b0, opnd};
    if (modo_mult) begin
      passo_hi = soma_parc[LARGURA:1];
      passo_lo = {soma_parc[0], acc_lo[LARGURA-1:1]};
    end else if (tentativa[LARGURA]) begin
      passo_hi = desloc[LARGURA-1:0];
      passo_lo = {acc_lo[LARGURA-2:0], 1'b0};
    end else begin
      passo_hi = tentativa[LARGURA-1:0];
      passo_lo = {acc_lo[LARGURA-2:0], 1'b1};
    end
    produto = neg_q ? -{passo_hi, passo_lo} : {passo_hi, passo_lo};
    quoc_f  = neg_q ? -passo_lo : passo_lo;
    resto_f = neg_r ? -passo_hi : passo_hi;
  end

  // Engine registers and held result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_hi    <= '0;
      acc_lo    <= '0;
      opnd      <= '0;
      cnt       <= '0;
      modo_mult <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      s0        <= '0;
      s1        <= '0;
      c0        <= 1'b0;
      z0        <= 1'b1;
      erro      <= 1'b0;
    end else if (aceita) begin
      modo_mult <= eh_mult;
      neg_q     <= sinal && (e0[LARGURA-1] ^ e1[LARGURA-1]);
      neg_r     <= sinal && e0[LARGURA-1];
      cnt       <= CNT_CARGA;
      if (eh_mult) begin
        acc_hi <= '0;
        acc_lo <= mag_b;
        opnd   <= mag_a;
      end else if (multiciclo) begin
        acc_hi <= '0;
        acc_lo <= mag_a;
        opnd   <= mag_b;
      end else if (div_zero) begin
        s0   <= '1;
        s1   <= e0;
        c0   <= 1'b0;
        z0   <= 1'b0;
        erro <= 1'b1;
      end else begin
        s0   <= res_simples;
        s1   <= '0;
        c0   <= c_simples;
        z0   <= (res_simples == '0);
        erro <= 1'b0;
      end
    end else if (estado == ITERA) begin
      cnt    <= cnt - 1'b1;
      acc_hi <= passo_hi;
      acc_lo <= passo_lo;
      if (cnt == '0) begin
        c0   <= 1'b0;
        erro <= 1'b0;
        if (modo_mult) begin
          s0 <= produto[LARGURA-1:0];
          s1 <= produto[2*LARGURA-1:LARGURA];
          z0 <= (produto[LARGURA-1:0] == '0);
        end else begin
          s0 <= quoc_f;
          s1 <= resto_f;
          z0 <= (quoc_f == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_ula_sequencial.sv
// Bench for ula_sequencial: directed corner cases plus random operations,
// compared against an arithmetic reference model.
module tb_ula_sequencial;

  logic        clock = 1'b0;
  logic        reset, inicio;
  logic [5:0]  seletor;
  logic [31:0] e0, e1, s0, s1;
  logic        c0, z0, erro, ocupado, pronto;

  int checks = 0;
  int errors = 0;

  logic [31:0] esp_s0, esp_s1;
  logic        esp_c0, esp_erro;
  int          esp_lat;

  ula_sequencial #(.LARGURA(32), .LOG_LARGURA(5)) dut (
    .clock(clock), .reset(reset), .inicio(inicio), .seletor(seletor),
    .e0(e0), .e1(e1), .s0(s0), .s1(s1), .c0(c0), .z0(z0),
    .erro(erro), .ocupado(ocupado), .pronto(pronto)
  );

  always #5 clock = ~clock;

  task automatic verificar(input string tag, input logic [63:0] obs, input logic [63:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s obs=%h esp=%h", tag, obs, esp);
    end
  endtask

  function automatic void modelo(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r0, output logic [31:0] r1,
                                 output logic rc, output logic rerro, output int lat);
    logic        sg;
    logic [4:0]  op;
    logic [63:0] p;
    longint      la, lb;
    int          ia, ib;
    r0 = 0; r1 = 0; rc = 0; rerro = 0; lat = 1;
    sg = sel[5];
    op = sel[4:0];
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      5'd0:  r0 = a + b;
      5'd1:  r0 = a - b;
      5'd2: begin
        if (sg) begin la = longint'(ia); lb = longint'(ib); p = 64'(la * lb); end
        else    p = {32'd0, a} * {32'd0, b};
        r0 = p[31:0]; r1 = p[63:32]; lat = 33;
      end
      5'd3: begin
        if (b == 0) begin r0 = 32'hFFFF_FFFF; r1 = a; rerro = 1; end
        else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r0 = a; r1 = 0; lat = 33; end
        else if (sg) begin r0 = 32'(ia / ib); r1 = 32'(ia % ib); lat = 33; end
        else begin r0 = a / b; r1 = a % b; lat = 33; end
      end
      5'd4:  r0 = a | b;
      5'd5:  r0 = ~(a | b);
      5'd6:  r0 = a & b;
      5'd7:  r0 = ~(a & b);
      5'd8:  r0 = a ^ b;
      5'd9:  r0 = ~(a ^ b);
      5'd10: begin rc = sg ? (ia < ib) : (a < b); r0 = {31'd0, rc}; end
      5'd11: begin rc = sg ? (ia > ib) : (a > b); r0 = {31'd0, rc}; end
      5'd12: begin rc = (a == b); r0 = {31'd0, rc}; end
      5'd15: begin rc = (a != b); r0 = {31'd0, rc}; end
      5'd13: r0 = (b >= 32) ? 32'd0 : (a << b[4:0]);
      5'd14: begin
        if (b >= 32) r0 = (sg && a[31]) ? 32'hFFFF_FFFF : 32'd0;
        else if (sg) r0 = 32'(ia >>> b[4:0]);
        else         r0 = a >> b[4:0];
      end
      5'd16: r0 = a;
      5'd17: r0 = ~a;
      default: r0 = b;
    endcase
  endfunction

  // Drive a request at a negedge; returns just after the accepting edge
  // with the operands scrambled to show they are no longer looked at.
  task automatic iniciar(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b);
    seletor = sel; e0 = a; e1 = b; inicio = 1'b1;
    modelo(sel, a, b, esp_s0, esp_s1, esp_c0, esp_erro, esp_lat);
    @(posedge clock);
    #1;
    inicio = 1'b0;
    seletor = 6'($urandom);
    e0 = $urandom;
    e1 = $urandom;
  endtask

  task automatic aguardar(input int lat0, input int ocup0);
    int lat, nocup;
    lat = lat0; nocup = ocup0;
    while (1) begin
      @(negedge clock);
      lat++;
      if (pronto || lat > 200) break;
      if (ocupado) nocup++;
    end
    verificar("pronto_no_prazo", pronto, 1);
    verificar("latencia", lat, esp_lat);
    verificar("ciclos_ocupado", nocup, esp_lat - 1);
    verificar("ocupado_em_fim", ocupado, 0);
    verificar("s0", s0, esp_s0);
    verificar("s1", s1, esp_s1);
    verificar("c0", c0, esp_c0);
    verificar("z0", z0, esp_s0 == 0);
    verificar("erro", erro, esp_erro);
  endtask

  task automatic fim_pulso();
    @(negedge clock);
    verificar("pronto_um_ciclo", pronto, 0);
    verificar("s0_mantido", s0, esp_s0);
    verificar("s1_mantido", s1, esp_s1);
  endtask

  task automatic executar(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b);
    iniciar(sel, a, b);
    aguardar(0, 0);
    fim_pulso();
  endtask

  function automatic logic [31:0] aleat();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int pulsos, nocup;
    logic [4:0] op;
    logic [31:0] a, b;

    reset = 1'b1; inicio = 1'b0; seletor = '0; e0 = '0; e1 = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    verificar("rst_s0", s0, 0);
    verificar("rst_s1", s1, 0);
    verificar("rst_z0", z0, 1);
    verificar("rst_c0", c0, 0);
    verificar("rst_erro", erro, 0);
    verificar("rst_ocupado", ocupado, 0);
    pulsos = 0;
    repeat (10) begin @(negedge clock); if (pronto) pulsos++; end
    verificar("ocioso_sem_pronto", pulsos, 0);

    executar(6'h00, 32'hFFFF_FFFF, 32'd1);
    executar(6'h02, 32'h8000_0000, 32'd4);
    executar(6'h22, 32'h8000_0000, 32'd4);
    executar(6'h03, 32'd100, 32'd7);
    executar(6'h23, 32'hFFFF_FFF9, 32'd2);
    executar(6'h03, 32'd100, 32'd0);
    executar(6'h23, 32'h8000_0000, 32'hFFFF_FFFF);
    executar(6'h0A, 32'hFFFF_FFFF, 32'd1);
    executar(6'h2A, 32'hFFFF_FFFF, 32'd1);
    executar(6'h2E, 32'h8000_0000, 32'd40);
    executar(6'h0E, 32'h8000_0000, 32'd40);
    executar(6'h0D, 32'h0000_0003, 32'd31);

    // back-to-back: new request while pronto is high
    iniciar(6'h00, 32'd10, 32'd20);
    aguardar(0, 0);
    iniciar(6'h02, 32'd3, 32'd5);
    aguardar(0, 0);
    fim_pulso();

    // inicio while busy is ignored
    iniciar(6'h02, 32'd7, 32'd9);
    nocup = 0;
    for (int i = 1; i <= 5; i++) begin @(negedge clock); if (ocupado) nocup++; end
    inicio = 1'b1; seletor = 6'h00; e0 = 32'd1; e1 = 32'd1;
    @(negedge clock);
    if (ocupado) nocup++;
    inicio = 1'b0;
    aguardar(6, nocup);
    fim_pulso();

    // reset mid-operation aborts
    iniciar(6'h02, 32'h1234, 32'h5678);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    verificar("abort_s0", s0, 0);
    verificar("abort_s1", s1, 0);
    verificar("abort_z0", z0, 1);
    verificar("abort_ocupado", ocupado, 0);
    verificar("abort_pronto", pronto, 0);
    executar(6'h00, 32'd5, 32'd6);
    pulsos = 0;
    repeat (40) begin @(negedge clock); if (pronto) pulsos++; end
    verificar("abort_sem_pronto", pulsos, 0);

    // random operations, occasionally back-to-back
    for (int n = 0; n < 200; n++) begin
      op = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(2, 3));
      a = aleat();
      b = aleat();
      if (op == 5'd13 || op == 5'd14) b = 32'($urandom_range(0, 40));
      iniciar({1'($urandom_range(0, 1)), op}, a, b);
      aguardar(0, 0);
      if ($urandom_range(0, 3) != 0) fim_pulso();
    end
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
